// File: rtl/accumulator_differencer.sv
// rtl/accumulator_differencer.sv - decodes running-sum samples into modulo-2^WIDTH deltas behind a 2-entry skid
module accumulator_differencer #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 s_valid,
   input  logic [WIDTH-1:0]     s_data,
   output logic                 s_ready,
   output logic                 m_valid,
   output logic [WIDTH-1:0]     m_data,
   input  logic                 m_ready,
   output logic [CNT_WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_prev;
   logic [WIDTH-1:0]     r_main;
   logic [WIDTH-1:0]     r_skid;
   logic [WIDTH-1:0]     w_main_nxt;
   logic [WIDTH-1:0]     w_skid_nxt;
   logic [WIDTH-1:0]     w_delta;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 w_accept;
   logic                 w_pop;

   // Ready depends only on registered occupancy and clear, so backpressure
   // from m_ready never ripples combinationally upstream.
   assign s_ready  = (r_state != ST_TWO) & ~clear;
   assign m_valid  = (r_state != ST_EMPTY);
   assign m_data   = r_main;
   assign count    = r_count;

   assign w_accept = s_valid & s_ready;
   assign w_pop    = m_valid & m_ready;

   // Unsigned subtraction wraps naturally, which is exactly the inverse of
   // an accumulator that wraps on overflow.
   assign w_delta  = s_data - r_prev;

   // Occupancy next-state and main/skid load selection; clear beats everything.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (clear) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = w_delta;
               end
            end
            ST_ONE: begin
               case ({w_accept, w_pop})
                  2'b10: begin
                     w_state_nxt = ST_TWO;
                     w_skid_nxt  = w_delta;
                  end
                  2'b01: begin
                     w_state_nxt = ST_EMPTY;
                  end
                  2'b11: begin
                     w_main_nxt  = w_delta;
                  end
                  default: begin
                     w_state_nxt = ST_ONE;
                  end
               endcase
            end
            ST_TWO: begin
               // s_ready is low here, so only a pop can move us.
               if (w_pop) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = r_skid;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Occupancy state and output stage registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   // Previous-sample reference and accepted-sample counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prev  <= '0;
         r_count <= '0;
      end else if (clear) begin
         r_prev  <= '0;
         r_count <= '0;
      end else if (w_accept) begin
         r_prev  <= s_data;
         r_count <= r_count + CNT_ONE;
      end
   end

endmodule
